// File: rtl/led_enable_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_enable_ctrl
// Description : Button-driven display-enable controller for the LED sweeper.
//               A bouncing push-button is synchronized and debounced. Each
//               debounced press steps a mode cycle OFF -> ON -> BLINK -> OFF.
//               In BLINK the enable output toggles every BLINK_HALF_PERIOD
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module led_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int BLINK_HALF_PERIOD = 1000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn,
  output logic       o_display_enable,
  output logic [1:0] o_mode,
  output logic       o_btn_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10
  } mode_e;

  logic            sync1_q;
  logic            sync2_q;
  logic            btn_db_q;
  logic            btn_db_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            btn_db_dly_q;
  logic            pulse_q;

  // The mode register is a plain vector so an out-of-range code (2'b11)
  // can exist and be recovered from.
  logic [1:0]      mode_q;
  logic [1:0]      mode_d;
  logic            en_q;
  logic            en_d;
  logic [BL_W-1:0] blink_cnt_q;
  logic [BL_W-1:0] blink_cnt_d;
  logic            phase_q;
  logic            phase_d;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: the level only follows sync2 after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles; any shorter excursion restarts the count.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      btn_db_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Debounce state plus rising-edge detection of the debounced level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btn_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      btn_db_dly_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      btn_db_q     <= btn_db_d;
      db_cnt_q     <= db_cnt_d;
      btn_db_dly_q <= btn_db_q;
      pulse_q      <= btn_db_q & ~btn_db_dly_q;
    end
  end

  // Mode sequencing, blink generation and enable derived from the next mode,
  // so the enable changes on the same edge as the mode.
  always_comb begin
    mode_d      = mode_q;
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    en_d        = 1'b0;

    case (mode_q)
      MODE_OFF:   if (pulse_q) mode_d = MODE_ON;
      MODE_ON:    if (pulse_q) mode_d = MODE_BLINK;
      MODE_BLINK: if (pulse_q) mode_d = MODE_OFF;
      default:    mode_d = MODE_OFF;
    endcase

    // Entry restarts the counter with phase high; counter and phase are
    // parked at zero whenever the next mode is not BLINK.
    if (mode_d == MODE_BLINK) begin
      if (mode_q != MODE_BLINK) begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end else if (blink_cnt_q == BL_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end

    case (mode_d)
      MODE_ON:    en_d = 1'b1;
      MODE_BLINK: en_d = phase_d;
      default:    en_d = 1'b0;
    endcase
  end

  // Mode, enable and blink state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mode_q      <= MODE_OFF;
      en_q        <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      en_q        <= en_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign o_mode           = mode_q;
  assign o_display_enable = en_q;
  assign o_btn_pulse      = pulse_q;

`ifdef FORMAL
  // Mode stays legal and OFF always means display disabled.
  always_comb begin
    if (!i_reset) begin
      assert (o_mode != 2'b11);
      assert (o_mode != MODE_OFF || !o_display_enable);
      cover (o_mode == MODE_BLINK && !o_display_enable);
    end
  end
`endif

endmodule
`default_nettype wire
